// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and default widths for the unified memory port
package cpu_pkg;

    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_streak_counter.sv
// rtl/arb_streak_counter.sv - saturating count of consecutive DM wins over a waiting IF
module arb_streak_counter #(
    parameter int MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CNT_W = $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign sat_o = (count_q == CNT_W'(MAX_COUNT));

    // Clear dominates so an IF grant always restarts the streak.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !sat_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one pipelined single-port memory between fetch and load/store
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W        = MEM_ADDR_W,
    parameter int DATA_W        = MEM_DATA_W,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    logic   streak_sat;
    logic   if_win;
    owner_t owner_q, owner_d;

    // IF wins when alone or once DM has used up its allowed streak.
    assign if_win   = if_req_i & (~dm_req_i | streak_sat);
    assign if_gnt_o = rst & if_win;
    assign dm_gnt_o = rst & dm_req_i & ~if_win;

    arb_streak_counter #(
        .MAX_COUNT (MAX_DM_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc_i (dm_gnt_o & if_req_i),
        .clr_i (if_gnt_o | ~if_req_i),
        .sat_o (streak_sat)
    );

    assign mem_en_o    = if_gnt_o | dm_gnt_o;
    assign mem_we_o    = dm_gnt_o & dm_we_i;
    assign mem_wdata_o = dm_wdata_i;

    always_comb begin
        mem_addr_o = '0;
        if (dm_gnt_o) begin
            mem_addr_o = dm_addr_i;
        end else if (if_gnt_o) begin
            mem_addr_o = if_addr_i;
        end
    end

    // Stores complete at grant, so only reads claim the next-cycle response slot.
    always_comb begin
        owner_d = OWN_NONE;
        if (if_gnt_o) begin
            owner_d = OWN_IF;
        end else if (dm_gnt_o && !dm_we_i) begin
            owner_d = OWN_DM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign if_rvalid_o = (owner_q == OWN_IF);
    assign dm_rvalid_o = (owner_q == OWN_DM);
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [5:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_DM_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory macro: synchronous, one-cycle read latency, preloaded while mem_load is high.
    logic [31:0] mem [64];
    logic [31:0] init_mem [64];
    logic        mem_load;
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: memory contents, streak length, expected read responses.
    typedef struct {
        int          cyc;
        bit          is_dm;
        logic [31:0] data;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] ref_mem [64];
    int          ref_streak = 0;
    int          last_win = 0;   // 0 none, 1 IF, 2 DM

    task automatic model_check();
        int   win;
        exp_t e;
        if (dm_req && !(if_req && ref_streak >= MAX)) win = 2;
        else if (if_req)                                win = 1;
        else                                            win = 0;
        chk("if_gnt", if_gnt, win == 1);
        chk("dm_gnt", dm_gnt, win == 2);
        chk("mem_en", mem_en, win != 0);
        chk("mem_we", mem_we, (win == 2) && dm_we);
        chk("mem_addr", mem_addr, win == 2 ? dm_addr : (win == 1 ? if_addr : 6'd0));
        if (win == 2 && dm_we) begin
            chk("mem_wdata", mem_wdata, dm_wdata);
            ref_mem[dm_addr] = dm_wdata;
        end
        if (win == 1) begin
            e.cyc = cyc + 1; e.is_dm = 1'b0; e.data = ref_mem[if_addr];
            exp_q.push_back(e);
        end else if (win == 2 && !dm_we) begin
            e.cyc = cyc + 1; e.is_dm = 1'b1; e.data = ref_mem[dm_addr];
            exp_q.push_back(e);
        end
        if (if_req && win == 2) ref_streak = (ref_streak + 1 > MAX) ? MAX : ref_streak + 1;
        else                    ref_streak = 0;
        last_win = win;
    endtask

    // Monitor: each response must arrive exactly one cycle after its grant, on its own port only.
    always @(negedge clk) begin
        if (rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_total++;
                $display("FAIL rvalid_missing: got no response expected one at cycle %0d", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_dm) begin
                    chk("dm_rvalid", dm_rvalid, 1);
                    chk("dm_rdata", dm_rdata, e.data);
                    chk("if_rvalid_quiet", if_rvalid, 0);
                    chk("if_rdata_quiet", if_rdata, 0);
                end else begin
                    chk("if_rvalid", if_rvalid, 1);
                    chk("if_rdata", if_rdata, e.data);
                    chk("dm_rvalid_quiet", dm_rvalid, 0);
                    chk("dm_rdata_quiet", dm_rdata, 0);
                end
            end else begin
                chk("no_if_rvalid", if_rvalid, 0);
                chk("no_dm_rvalid", dm_rvalid, 0);
            end
        end
    end

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
        init_mem[5] = 32'h00500093;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
        mem_load = 1'b1;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 6'd1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 6'd2; dm_wdata = 32'd0;

        // Reset with both requesters active: every output quiet.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_dm_rvalid", dm_rvalid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        adv();
        mem_load = 1'b0;
        rst = 1'b1;

        // Continuous contention: DM x4 then a forced IF, repeated.
        for (int i = 0; i < 10; i++) begin
            sample();
            chk($sformatf("starve_seq%0d", i), {if_gnt, dm_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
            if (i == 0) chk("first_no_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
            adv();
        end
        if_req = 1'b0; dm_req = 1'b0;
        sample(); adv();

        // Fetch alone.
        if_req = 1'b1; if_addr = 6'd5;
        sample();
        chk("if5_gnt", if_gnt, 1);
        chk("if5_mem_addr", mem_addr, 5);
        adv();
        if_req = 1'b0;
        sample();
        chk("if5_rvalid", if_rvalid, 1);
        chk("if5_rdata", if_rdata, 32'h00500093);
        adv();

        // Store followed immediately by a load of the same word.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 6'd3; dm_wdata = 32'hDEADBEEF;
        sample();
        chk("st_gnt", dm_gnt, 1);
        adv();
        dm_we = 1'b0;
        sample();
        chk("ld_gnt", dm_gnt, 1);
        chk("st_no_rvalid", dm_rvalid, 0);
        adv();
        dm_req = 1'b0;
        sample();
        chk("ld_rvalid", dm_rvalid, 1);
        chk("ld_rdata", dm_rdata, 32'hDEADBEEF);
        adv();

        // Interleaved routing: DM load of 7, IF fetch of 8.
        for (int i = 0; i < 4; i++) begin
            if_req = (i % 2 == 1); if_addr = 6'd8;
            dm_req = (i % 2 == 0); dm_we = 1'b0; dm_addr = 6'd7;
            sample(); adv();
        end
        if_req = 1'b0; dm_req = 1'b0;
        sample(); adv();

        // Reset while a fetch response is in flight.
        if_req = 1'b1; if_addr = 6'd9;
        sample();
        chk("mid_if_gnt", if_gnt, 1);
        adv();
        rst = 1'b0; if_req = 1'b0;
        exp_q.delete();
        ref_streak = 0;
        @(negedge clk);
        chk("mid_if_rvalid", if_rvalid, 0);
        chk("mid_if_rdata", if_rdata, 0);
        chk("mid_owner", dut.owner_q, OWN_NONE);
        adv();
        rst = 1'b1;
        sample(); adv();

        // Randomized traffic; a request is held until the model says it was granted.
        for (int i = 0; i < 400; i++) begin
            sample();
            adv();
            if (!if_req || last_win == 1) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 6'($urandom_range(0, 63));
            end
            if (!dm_req || last_win == 2) begin
                dm_req   = ($urandom_range(0, 3) != 0);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_addr  = 6'($urandom_range(0, 63));
                dm_wdata = $urandom;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (2) begin
            sample(); adv();
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
